// File: rtl/ci_sequencer_pkg.sv
// Purpose: shared widths, opcode encodings and FSM state encoding for the CI/PI sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ci_sequencer_pkg;

    localparam int CI_ADDR_BITS = 5;
    localparam int CI_WORD_BITS = 32;
    localparam int CI_FUNC_BITS = 6;
    // Function field sits at bits FUNC_LSB.. of the store word; line field at bits 0..ADDR_BITS-1.
    localparam int CI_FUNC_LSB  = 13;

    localparam logic [CI_FUNC_BITS-1:0] INST_JMP = 6'b000000;
    localparam logic [CI_FUNC_BITS-1:0] INST_JRP = 6'b000001;
    localparam logic [CI_FUNC_BITS-1:0] INST_CMP = 6'b000011;
    localparam logic [CI_FUNC_BITS-1:0] INST_HLT = 6'b111111;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SCAN_INC   = 2'd1,
        SCAN_FETCH = 2'd2,
        ACTION     = 2'd3
    } seq_state_t;

endpackage

// File: rtl/ci_next_calc.sv
// Purpose: combinational next-CI value applied at action time, selected by the PI opcode.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the result is committed.
// Ports: op (PI function field), ci (current CI), operand (line field of the
//        addressed store word), acc_neg (accumulator sign) -> ci_next.
module ci_next_calc
    import ci_sequencer_pkg::*;
#(
    parameter int ADDR_BITS = CI_ADDR_BITS
) (
    input  logic [CI_FUNC_BITS-1:0] op,
    input  logic [ADDR_BITS-1:0]    ci,
    input  logic [ADDR_BITS-1:0]    operand,
    input  logic                    acc_neg,
    output logic [ADDR_BITS-1:0]    ci_next
);

    always_comb begin
        ci_next = ci;
        case (op)
            INST_JMP: ci_next = operand;
            // Sum naturally truncates to ADDR_BITS, giving the modulo wrap.
            INST_JRP: ci_next = ci + operand;
            INST_CMP: ci_next = acc_neg ? ci + 1'b1 : ci;
            INST_HLT: ci_next = ci;
            default:  ci_next = ci;
        endcase
    end

endmodule

// File: rtl/ci_sequencer.sv
// Purpose: CI/PI sequencer; increments CI each bar, fetches PI, drives line address and b_FST, applies jumps/skips.
// Latency: CI increments 1 cycle after w_S1 is sampled; b_FST valid the cycle after w_INSTR_GATE is sampled.
// Backpressure: ready=0 freezes every register; the FSM waits indefinitely for the gate and the action trigger.
// Ports: w_CLK, w_RESET_N (sync, active-low), ready, w_S1, w_INSTR_GATE, w_ACTION_TRIGGER_AUTO,
//        b_STORE_WORD, w_ACC_NEG in; b_LINE_ADDR, b_FST, b_CI, w_FETCH, w_EXEC_STROBE, w_SEQ_ERR out.
// Optional: define CI_PRESET_EN to add w_CI_LOAD / b_CI_LOAD_VAL (load CI while IDLE).
module ci_sequencer
    import ci_sequencer_pkg::*;
#(
    parameter int ADDR_BITS           = CI_ADDR_BITS,
    parameter int WORD_BITS           = CI_WORD_BITS,
    parameter int INSTR_FUNCTION_BITS = CI_FUNC_BITS,
    parameter int FUNC_LSB            = CI_FUNC_LSB
) (
    input  logic                           w_CLK,
    input  logic                           w_RESET_N,
    input  logic                           ready,
    input  logic                           w_S1,
    input  logic                           w_INSTR_GATE,
    input  logic                           w_ACTION_TRIGGER_AUTO,
    input  logic [0:WORD_BITS-1]           b_STORE_WORD,
    input  logic                           w_ACC_NEG,
`ifdef CI_PRESET_EN
    input  logic                           w_CI_LOAD,
    input  logic [0:ADDR_BITS-1]           b_CI_LOAD_VAL,
`endif
    output logic [0:ADDR_BITS-1]           b_LINE_ADDR,
    output logic [0:INSTR_FUNCTION_BITS-1] b_FST,
    output logic [0:ADDR_BITS-1]           b_CI,
    output logic                           w_FETCH,
    output logic                           w_EXEC_STROBE,
    output logic                           w_SEQ_ERR
);

    seq_state_t                     state_q, state_d;
    logic [ADDR_BITS-1:0]           ci_q, ci_d, ci_calc, line_addr;
    logic [WORD_BITS-1:0]           word, pi_q, pi_d;
    logic [INSTR_FUNCTION_BITS-1:0] fst_q, fst_d;
    logic                           strobe_q, strobe_d;
    logic                           err_q, err_d;
    logic                           load_req;
    logic [ADDR_BITS-1:0]           load_val;
    logic                           unused_word_bits;

    // Re-view the ascending-range store bus numerically so field slices read as bit weights.
    assign word = b_STORE_WORD;

`ifdef CI_PRESET_EN
    assign load_req = w_CI_LOAD;
    assign load_val = b_CI_LOAD_VAL;
`else
    assign load_req = 1'b0;
    assign load_val = '0;
`endif

    // Only the line and function fields are consumed downstream.
    assign unused_word_bits = ^{word, pi_q};

    // Operand is the word at the PI line (the store is addressed by PI during ACTION).
    ci_next_calc #(
        .ADDR_BITS (ADDR_BITS)
    ) u_next (
        .op      (pi_q[FUNC_LSB +: INSTR_FUNCTION_BITS]),
        .ci      (ci_q),
        .operand (word[ADDR_BITS-1:0]),
        .acc_neg (w_ACC_NEG),
        .ci_next (ci_calc)
    );

    always_ff @(posedge w_CLK) begin
        if (!w_RESET_N) begin
            state_q  <= IDLE;
            ci_q     <= '0;
            pi_q     <= '0;
            fst_q    <= '0;
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
        end else if (ready) begin
            state_q  <= state_d;
            ci_q     <= ci_d;
            pi_q     <= pi_d;
            fst_q    <= fst_d;
            strobe_q <= strobe_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ci_d      = ci_q;
        pi_d      = pi_q;
        fst_d     = fst_q;
        strobe_d  = 1'b0;
        err_d     = err_q;
        line_addr = ci_q;
        case (state_q)
            IDLE: begin
                // A preset load takes priority and swallows a coincident w_S1 silently.
                if (load_req) begin
                    ci_d = load_val;
                end else if (w_S1) begin
                    state_d = SCAN_INC;
                end
            end
            SCAN_INC: begin
                ci_d    = ci_q + 1'b1;
                state_d = SCAN_FETCH;
                if (w_S1) err_d = 1'b1;
            end
            SCAN_FETCH: begin
                if (w_S1) err_d = 1'b1;
                if (w_INSTR_GATE) begin
                    pi_d    = word;
                    fst_d   = word[FUNC_LSB +: INSTR_FUNCTION_BITS];
                    state_d = ACTION;
                end
            end
            ACTION: begin
                line_addr = pi_q[ADDR_BITS-1:0];
                // w_S1 here still flags an error; the bar it heralds is dropped.
                if (w_S1) err_d = 1'b1;
                if (w_ACTION_TRIGGER_AUTO) begin
                    ci_d     = ci_calc;
                    strobe_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign b_LINE_ADDR   = line_addr;
    assign b_CI          = ci_q;
    assign b_FST         = fst_q;
    assign w_FETCH       = (state_q == SCAN_INC) || (state_q == SCAN_FETCH);
    assign w_EXEC_STROBE = strobe_q;
    assign w_SEQ_ERR     = err_q;

endmodule

// File: tb/tb_ci_sequencer.sv
// Purpose: self-checking bench for ci_sequencer; directed scenarios plus random bars against a bar-level model.
// Latency: inputs driven after the falling edge, outputs sampled at the following falling edge.
// Backpressure: exercises ready=0 stalls and delayed gate/trigger.
module tb_ci_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, ready, s1, gate, trig, acc_neg;
    logic [0:31] store_word;
    logic [0:4]  line_addr, ci;
    logic [0:5]  fst;
    logic        fetch, strobe, err;
`ifdef CI_PRESET_EN
    logic        ci_load;
    logic [0:4]  ci_load_val;
`endif

    logic [31:0] mem [32];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign store_word = mem[line_addr];

    ci_sequencer dut (
        .w_CLK                 (clk),
        .w_RESET_N             (rst_n),
        .ready                 (ready),
        .w_S1                  (s1),
        .w_INSTR_GATE          (gate),
        .w_ACTION_TRIGGER_AUTO (trig),
        .b_STORE_WORD          (store_word),
        .w_ACC_NEG             (acc_neg),
`ifdef CI_PRESET_EN
        .w_CI_LOAD             (ci_load),
        .b_CI_LOAD_VAL         (ci_load_val),
`endif
        .b_LINE_ADDR           (line_addr),
        .b_FST                 (fst),
        .b_CI                  (ci),
        .w_FETCH               (fetch),
        .w_EXEC_STROBE         (strobe),
        .w_SEQ_ERR             (err)
    );

    function automatic logic [31:0] mk(input int func, input int line);
        return (32'(func) << 13) | 32'(line);
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; s1 = 1'b0; gate = 1'b0; trig = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic start_bar();
        s1 = 1'b1; tick(); s1 = 1'b0; tick();
    endtask

    task automatic do_fetch();
        gate = 1'b1; tick(); gate = 1'b0;
    endtask

    task automatic do_trigger(input logic neg);
        acc_neg = neg; trig = 1'b1; tick(); trig = 1'b0;
    endtask

    // Reset, then jump to `target` via a JMP at line 1 reading its operand from line 20.
    task automatic goto_ci(input int target);
        do_reset();
        mem[1]  = mk(0, 20);
        mem[20] = 32'(target);
        start_bar(); do_fetch(); do_trigger(1'b0); tick();
    endtask

    task automatic test_reset();
        ready = 1'b1; acc_neg = 1'b0;
        do_reset();
        checks++; if (ci !== 5'd0) begin errors++; $display("FAIL reset_ci: got %0d expected 0", ci); end
        checks++; if (fst !== 6'd0) begin errors++; $display("FAIL reset_fst: got %0d expected 0", fst); end
        checks++; if ({fetch, strobe, err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {fetch, strobe, err}); end
        checks++; if (line_addr !== 5'd0) begin errors++; $display("FAIL reset_line: got %0d expected 0", line_addr); end
    endtask

    task automatic test_basic_bar();
        mem[1] = mk(7, 5);
        start_bar();
        checks++; if (ci !== 5'd1) begin errors++; $display("FAIL basic_ci_inc: got %0d expected 1", ci); end
        checks++; if (fetch !== 1'b1 || line_addr !== 5'd1) begin errors++; $display("FAIL basic_fetch: fetch=%b line=%0d expected 1/1", fetch, line_addr); end
        do_fetch();
        checks++; if (fst !== 6'd7) begin errors++; $display("FAIL basic_fst: got %0d expected 7", fst); end
        checks++; if (line_addr !== 5'd5 || fetch !== 1'b0) begin errors++; $display("FAIL basic_action_line: line=%0d fetch=%b expected 5/0", line_addr, fetch); end
        do_trigger(1'b0);
        checks++; if (strobe !== 1'b1 || ci !== 5'd1) begin errors++; $display("FAIL basic_exec: strobe=%b ci=%0d expected 1/1", strobe, ci); end
        tick();
        checks++; if (strobe !== 1'b0 || ci !== 5'd1) begin errors++; $display("FAIL basic_strobe_pulse: strobe=%b ci=%0d expected 0/1", strobe, ci); end
    endtask

    task automatic test_jmp();
        goto_ci(2);
        mem[3] = mk(0, 9); mem[9] = 32'h0000000C; mem[13] = mk(7, 0);
        start_bar();
        checks++; if (ci !== 5'd3) begin errors++; $display("FAIL jmp_pre_ci: got %0d expected 3", ci); end
        do_fetch();
        checks++; if (line_addr !== 5'd9) begin errors++; $display("FAIL jmp_line: got %0d expected 9", line_addr); end
        do_trigger(1'b0);
        checks++; if (ci !== 5'd12) begin errors++; $display("FAIL jmp_ci: got %0d expected 12", ci); end
        start_bar();
        checks++; if (ci !== 5'd13) begin errors++; $display("FAIL jmp_next_bar: got %0d expected 13", ci); end
        do_fetch(); do_trigger(1'b0); tick();
    endtask

    task automatic test_wrap_jrp();
        goto_ci(31);
        mem[0] = mk(7, 0);
        start_bar();
        checks++; if (ci !== 5'd0) begin errors++; $display("FAIL wrap_ci: got %0d expected 0", ci); end
        do_fetch(); do_trigger(1'b0); tick();
        goto_ci(29);
        mem[30] = mk(1, 11); mem[11] = 32'd5;
        start_bar(); do_fetch(); do_trigger(1'b0);
        checks++; if (ci !== 5'd3) begin errors++; $display("FAIL jrp_wrap: got %0d expected 3", ci); end
    endtask

    task automatic test_cmp();
        for (int n = 1; n >= 0; n--) begin
            goto_ci(3);
            mem[4] = mk(3, 12); mem[12] = $urandom;
            start_bar(); do_fetch(); do_trigger(n[0]);
            checks++; if (ci !== 5'(4 + n)) begin errors++; $display("FAIL cmp_neg%0d: got %0d expected %0d", n, ci, 4 + n); end
            tick();
        end
    endtask

    task automatic test_hlt_seq_err();
        do_reset();
        mem[1] = mk(63, 2); mem[2] = mk(7, 0);
        start_bar(); do_fetch(); do_trigger(1'b0);
        repeat (3) tick();
        checks++; if (fst !== 6'd63 || ci !== 5'd1) begin errors++; $display("FAIL hlt_hold: fst=%0d ci=%0d expected 63/1", fst, ci); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clean: got %b expected 0", err); end
        start_bar();
        s1 = 1'b1; tick(); s1 = 1'b0;
        checks++; if (err !== 1'b1 || fetch !== 1'b1 || ci !== 5'd2) begin errors++; $display("FAIL s1_in_fetch: err=%b fetch=%b ci=%0d expected 1/1/2", err, fetch, ci); end
        do_fetch(); do_trigger(1'b0); repeat (3) tick();
        checks++; if (err !== 1'b1 || fst !== 6'd7) begin errors++; $display("FAIL err_sticky: err=%b fst=%0d expected 1/7", err, fst); end
        // w_S1 coincident with the action trigger.
        do_reset();
        mem[1] = mk(0, 4); mem[4] = 32'd17;
        start_bar(); do_fetch();
        s1 = 1'b1; trig = 1'b1; tick(); s1 = 1'b0; trig = 1'b0;
        checks++; if (strobe !== 1'b1 || ci !== 5'd17 || err !== 1'b1) begin errors++; $display("FAIL s1_with_trig: strobe=%b ci=%0d err=%b expected 1/17/1", strobe, ci, err); end
        tick();
        checks++; if (fetch !== 1'b0 || ci !== 5'd17) begin errors++; $display("FAIL s1_with_trig_nobar: fetch=%b ci=%0d expected 0/17", fetch, ci); end
        do_reset();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_reset: got %b expected 0", err); end
    endtask

    task automatic test_ready_and_reset();
        do_reset();
        mem[1] = mk(5, 9);
        start_bar();
        ready = 1'b0; gate = 1'b1; trig = 1'b1;
        repeat (10) tick();
        checks++; if (ci !== 5'd1 || fetch !== 1'b1 || fst !== 6'd0 || line_addr !== 5'd1) begin errors++; $display("FAIL ready_stall: ci=%0d fetch=%b fst=%0d line=%0d expected 1/1/0/1", ci, fetch, fst, line_addr); end
        trig = 1'b0; ready = 1'b1; tick(); gate = 1'b0;
        checks++; if (fst !== 6'd5 || line_addr !== 5'd9) begin errors++; $display("FAIL ready_resume: fst=%0d line=%0d expected 5/9", fst, line_addr); end
        // Reset in ACTION with ready low: reset still wins.
        ready = 1'b0; rst_n = 1'b0; tick(); rst_n = 1'b1; ready = 1'b1;
        checks++; if (ci !== 5'd0 || fst !== 6'd0 || fetch !== 1'b0 || line_addr !== 5'd0) begin errors++; $display("FAIL reset_in_action: ci=%0d fst=%0d fetch=%b line=%0d expected 0/0/0/0", ci, fst, fetch, line_addr); end
        trig = 1'b1; tick(); trig = 1'b0;
        checks++; if (strobe !== 1'b0) begin errors++; $display("FAIL trig_in_idle: got %b expected 0", strobe); end
    endtask

    task automatic test_random_bars();
        int m_ci, m_fst, m_line, opnd, k;
        logic neg;
        logic [31:0] w;
        do_reset();
        m_ci = 0;
        for (int i = 0; i < 32; i++) begin
            w = $urandom;
            k = $urandom_range(0, 4);
            case (k)
                0: w[18:13] = 6'b000000;
                1: w[18:13] = 6'b000001;
                2: w[18:13] = 6'b000011;
                3: w[18:13] = 6'b111111;
                default: ;
            endcase
            mem[i] = w;
        end
        for (int b = 0; b < 60; b++) begin
            repeat ($urandom_range(0, 2)) begin gate = 1'($urandom); tick(); end
            gate = 1'b0;
            start_bar();
            m_ci = (m_ci + 1) % 32;
            checks++; if (ci !== 5'(m_ci)) begin errors++; $display("FAIL rnd_inc[%0d]: got %0d expected %0d", b, ci, m_ci); end
            repeat ($urandom_range(0, 2)) begin trig = 1'($urandom); tick(); end
            trig = 1'b0;
            w = mem[m_ci];
            m_fst = int'(w[18:13]);
            m_line = int'(w[4:0]);
            do_fetch();
            checks++; if (fst !== 6'(m_fst) || line_addr !== 5'(m_line)) begin errors++; $display("FAIL rnd_fetch[%0d]: fst=%0d line=%0d expected %0d/%0d", b, fst, line_addr, m_fst, m_line); end
            repeat ($urandom_range(0, 2)) tick();
            neg = 1'($urandom);
            opnd = int'(mem[m_line] & 32'h1F);
            case (m_fst)
                0: m_ci = opnd;
                1: m_ci = (m_ci + opnd) % 32;
                3: if (neg) m_ci = (m_ci + 1) % 32;
                default: ;
            endcase
            do_trigger(neg);
            checks++; if (strobe !== 1'b1 || ci !== 5'(m_ci)) begin errors++; $display("FAIL rnd_exec[%0d]: strobe=%b ci=%0d expected 1/%0d", b, strobe, ci, m_ci); end
        end
        tick();
        checks++; if (err !== 1'b0 || strobe !== 1'b0) begin errors++; $display("FAIL rnd_final: err=%b strobe=%b expected 0/0", err, strobe); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        rst_n = 1'b0; ready = 1'b1; s1 = 1'b0; gate = 1'b0; trig = 1'b0; acc_neg = 1'b0;
`ifdef CI_PRESET_EN
        ci_load = 1'b0; ci_load_val = '0;
`endif
        tick();
        test_reset();
        test_basic_bar();
        test_jmp();
        test_wrap_jrp();
        test_cmp();
        test_hlt_seq_err();
        test_ready_and_reset();
        test_random_bars();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ci_sequencer.md
Name: ci_sequencer

Overview:
- Control Instruction (CI) / Present Instruction (PI) sequencer sitting directly downstream of the timing generator.
- Consumes the bar-start pulse w_S1, the instruction gate and the auto action trigger.
- Holds CI, increments it each bar and fetches the PI from store line CI.
- Drives the store line address and the function staticisor bus b_FST, which the stop unit consumes for halt detection.
- Applies jump, relative-jump and test-skip updates to CI at action time.

Parameters:
- ADDR_BITS, 5, width of CI and of the store line address.
- WORD_BITS, 32, store word width.
- INSTR_FUNCTION_BITS, 6, width of the function field and of b_FST.
- FUNC_LSB, 13, lowest bit index of the function field within the store word; the line field is bits 0..ADDR_BITS-1.
- INST_JMP, 6'b000000, opcode: CI <= store word.
- INST_JRP, 6'b000001, opcode: CI <= CI + store word.
- INST_CMP, 6'b000011, opcode: skip next instruction if accumulator negative.
- INST_HLT, 6'b111111, opcode: halt; passed through on b_FST only.

Ports:
- w_CLK  in  1  system clock.
- w_RESET_N  in  1  reset, synchronous, active-low.
- ready  in  1  global advance enable; no state change when 0.
- w_S1  in  1  bar-start scan pulse.
- w_INSTR_GATE  in  1  store read data valid for instruction fetch.
- w_ACTION_TRIGGER_AUTO  in  1  action-beat trigger.
- b_STORE_WORD  in  [0:WORD_BITS-1]  word read from the currently addressed line.
- w_ACC_NEG  in  1  accumulator sign bit.
- b_LINE_ADDR  out  [0:ADDR_BITS-1]  store line address.
- b_FST  out  [0:INSTR_FUNCTION_BITS-1]  function staticisor.
- b_CI  out  [0:ADDR_BITS-1]  current CI.
- w_FETCH  out  1  high while in SCAN_INC or SCAN_FETCH.
- w_EXEC_STROBE  out  1  one-cycle pulse when the action executes.
- w_SEQ_ERR  out  1  sticky; set by w_S1 arriving outside IDLE.

Behaviour:
- Reset (w_RESET_N=0 at posedge, overrides ready) clears all of the following to 0:
  - CI and PI;
  - b_FST (value 0, i.e. not HLT);
  - w_EXEC_STROBE and w_SEQ_ERR.
- The state machine resets to IDLE.
- Every non-reset update is gated by ready=1; with ready=0 all registers hold.
- FSM transitions:
  - IDLE: on w_S1 -> SCAN_INC.
  - SCAN_INC: CI <= CI+1 mod 2^ADDR_BITS; -> SCAN_FETCH next cycle.
  - SCAN_FETCH: b_LINE_ADDR = CI. On w_INSTR_GATE, PI <= b_STORE_WORD and b_FST <= PI function field (same edge) -> ACTION. Otherwise wait indefinitely.
  - ACTION: b_LINE_ADDR = PI line field. On w_ACTION_TRIGGER_AUTO, pulse w_EXEC_STROBE for 1 cycle and -> IDLE, applying the CI update for the opcode:
    - JMP: CI <= b_STORE_WORD[0:ADDR_BITS-1].
    - JRP: CI <= CI + b_STORE_WORD[0:ADDR_BITS-1], truncated mod 2^ADDR_BITS.
    - CMP: CI <= CI+1 if w_ACC_NEG, else CI unchanged.
    - Any other opcode, including HLT: CI unchanged.
- b_LINE_ADDR in IDLE = CI.
- b_FST holds its value from PI latch until the next PI latch.
- w_S1 in any non-IDLE state: ignored for sequencing, sets w_SEQ_ERR; cleared only by reset.
- w_S1 and w_ACTION_TRIGGER_AUTO together in ACTION: the action executes, the state goes to IDLE and w_SEQ_ERR is set; the new bar is not started.
- w_INSTR_GATE outside SCAN_FETCH and w_ACTION_TRIGGER_AUTO outside ACTION: ignored.
- Reset mid-bar: returns to IDLE immediately; any partial fetch is discarded.
- Latency: CI increments 1 cycle after w_S1 is sampled; b_FST is valid the cycle after the gate is sampled.

Optional Feature:
- Macro CI_PRESET_EN.
- When defined:
  - adds ports w_CI_LOAD (in 1) and b_CI_LOAD_VAL (in [0:ADDR_BITS-1]);
  - w_CI_LOAD=1 in IDLE with ready=1 sets CI <= b_CI_LOAD_VAL;
  - if w_S1 is high on the same cycle, the load wins and w_S1 is ignored without setting w_SEQ_ERR;
  - w_CI_LOAD in other states is ignored.
- When undefined: ports are absent and CI changes only via the FSM.

Decomposition:
- Shared timing package: opcode localparams (INST_JMP, INST_JRP, INST_CMP, INST_HLT), the FSM state encoding (IDLE=0, SCAN_INC=1, SCAN_FETCH=2, ACTION=3) and the field positions.
- One sub-module ci_next_calc (combinational next-CI from opcode, CI, store word and w_ACC_NEG) is natural.

Test Plan:
- Reset, then w_S1 pulse; gate with word having function 000111, line 00101.
  - Expect CI=1, then b_LINE_ADDR=5, b_FST=000111.
  - Trigger: w_EXEC_STROBE for 1 cycle, CI stays 1.
- CI=3, PI=JMP line 9, store word 0x0000000C: after trigger CI=12; next w_S1 gives CI=13.
- CI=31, w_S1: CI wraps to 0. JRP at CI=30 with word 5: CI=3.
- CMP with w_ACC_NEG=1 at CI=4: CI=5. With w_ACC_NEG=0: CI=4.
- HLT word (function 111111): b_FST=111111 holds through IDLE. w_S1 during SCAN_FETCH: w_SEQ_ERR=1 and remains 1 until reset.
- ready=0 for 10 cycles mid-SCAN_FETCH with gate asserted: no change. Reset in ACTION: IDLE, CI=0, b_FST=0.
